uart_tx_periph: RTL and testbench
=================================

# uart_tx_periph

Memory-mapped UART transmitter peripheral on the CPU data bus, clocked by `MAINCLK`. The CPU writes bytes into a small FIFO; an internal state machine serialises each byte as an 8N1 frame on `tx`. A status register exposes FIFO and shifter state so firmware can poll before writing. This is the CPU-to-outside-world path used by system-level benches to observe program output.

## Interface
- `CLK_DIV`, 16: `MAINCLK` cycles per serial bit; minimum 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, minimum 2.

- `MAINCLK` in 1: sole clock; all logic on rising edge.
- `MAINRST` in 1: asynchronous, active-high reset.
- `bus_sel` in 1: peripheral selected this cycle.
- `bus_addr` in 1: register select (0 = DATA, 1 = STATUS).
- `bus_we` in 1: write strobe, qualified by `bus_sel`.
- `bus_re` in 1: read strobe, qualified by `bus_sel`.
- `bus_wdata` in 8: write data.
- `bus_rdata` out 8: registered read data.
- `tx` out 1: serial output, idle high, registered.
- `tx_idle` out 1: high when FIFO empty and FSM in IDLE.

## Operation
- Write DATA (`sel&we`, addr 0): push `bus_wdata` if FIFO not full; if full, byte dropped and sticky `overflow` set. Fullness taken from pre-edge state: a push while full is dropped even if the FSM pops in the same cycle.
- Write STATUS (addr 1): `bus_wdata[0]=1` clears `overflow`; other bits ignored. A same-cycle overflow event wins over the clear.
- Read STATUS: `{4'b0, overflow, busy, empty, full}` (bit0 full, bit1 empty, bit2 busy = FSM not IDLE). Read DATA returns 0x00.
- `sel&we&re` together: write performed, read returns pre-write state.
- `bus_rdata` updated only on `sel&re`; otherwise holds.
- FIFO: circular, read/write pointers of log2(FIFO_DEPTH)+1 bits, wrap silently; simultaneous push and pop on non-full, non-empty FIFO leaves count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop into shift register, → START.
  - START: `tx`=0 for CLK_DIV cycles → DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit bit counter; after bit 7 → STOP.
  - STOP: `tx`=1 for CLK_DIV cycles; at end, if FIFO non-empty pop and → START directly (no gap), else → IDLE.
- Baud counter width clog2(CLK_DIV), reloads CLK_DIV−1 on each state entry/bit, bit ends when it reaches 0.

## Timing
- Reset (asynchronous): `tx`=1, `bus_rdata`=0x00, `tx_idle`=1, FIFO empty, `overflow`=0, FSM IDLE, counters 0.
- Reset mid-frame: `tx` returns high immediately, frame aborted, FIFO contents discarded.
- Write-to-start-bit latency, idle peripheral: write at edge N, pop at edge N+1, `tx` falls after edge N+2.
- Frame length exactly 10×CLK_DIV cycles; back-to-back frames contiguous.
- Read latency: one cycle (`bus_rdata` valid after the edge sampling `sel&re`).
- `tx_idle` falls the cycle after the first push; rises the cycle after STOP completes with FIFO empty.

## Test plan
- Reset: assert `MAINRST` mid-run → `tx`=1, `bus_rdata`=0x00, STATUS read = 0x02.
- Single byte, CLK_DIV=4: write 0x55 → `tx` low 4 cycles starting 2 cycles after write, then 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles; total 40 cycles; `tx_idle` back to 1.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles → 80 contiguous cycles, no idle gap between STOP and second START.
- Overflow, FIFO_DEPTH=4: six writes on consecutive cycles 0x01..0x06 → 0x06 dropped, STATUS=0x0D (full, busy, overflow); exactly 0x01..0x05 transmitted; write STATUS 0x01 → overflow clears.
- Reset mid-frame: assert `MAINRST` during DATA bit 3 → `tx` high immediately, no further frames after release, STATUS=0x02.
- Read/write collision: `sel&we&re` to STATUS with overflow set and wdata 0x01 → `bus_rdata` shows bit3=1, next read shows bit3=0.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// CPU data-bus port of the UART transmitter peripheral.
// Strobe bus, no handshake: a write/read takes effect on the rising edge that samples
// bus_sel with bus_we/bus_re; bus_rdata is registered, valid the cycle after a read.
interface uart_tx_periph_if;
    logic       bus_sel;
    logic       bus_addr;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    modport master (
        output bus_sel, bus_addr, bus_we, bus_re, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_sel, bus_addr, bus_we, bus_re, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, an FSM serialises them on tx.
// Register map: addr 0 = DATA (write pushes), addr 1 = STATUS {4'b0, overflow, busy, empty, full}.
module uart_tx_periph #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             MAINCLK,
    input  logic             MAINRST,
    uart_tx_periph_if.slave  bus,
    output logic             tx,
    output logic             tx_idle,
    output logic [1:0]       fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic          overflow;

    logic empty, full, busy, bit_end;
    logic data_wr, push, ovf_evt, ovf_clr, pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy    = (state != IDLE);
    assign bit_end = (baud == '0);

    // Fullness is the pre-edge value, so a push while full is dropped even if a pop coincides.
    assign data_wr = bus.bus_sel & bus.bus_we & ~bus.bus_addr;
    assign push    = data_wr & ~full;
    assign ovf_evt = data_wr & full;
    assign ovf_clr = bus.bus_sel & bus.bus_we & bus.bus_addr & bus.bus_wdata[0];
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

    assign tx_idle   = empty & (state == IDLE);
    assign fsm_state = state;

    always_ff @(posedge MAINCLK) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.bus_wdata;
    end

    always_ff @(posedge MAINCLK or posedge MAINRST) begin
        if (MAINRST) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            baud          <= '0;
            overflow      <= 1'b0;
            tx            <= 1'b1;
            bus.bus_rdata <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (ovf_evt)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (bus.bus_sel & bus.bus_re)
                bus.bus_rdata <= bus.bus_addr ? {4'b0, overflow, busy, empty, full} : 8'h00;

            // tx follows the pre-edge state, so the line lags the FSM by one cycle throughout.
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[0];
                default: tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_mem[rd_ptr[AW-1:0]];
                        baud    <= BAUD_LOAD;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud  <= BAUD_LOAD;
                        state <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud    <= BAUD_LOAD;
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg   <= fifo_mem[rd_ptr[AW-1:0]];
                            baud    <= BAUD_LOAD;
                            bit_cnt <= '0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph (CLK_DIV=4, FIFO_DEPTH=4): tx waveform recorded per cycle
// and compared against frames built from an expected-byte queue.
module tb_uart_tx_periph;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;
    localparam int HIST       = 4096;

    logic       MAINCLK;
    logic       MAINRST;
    logic       tx;
    logic       tx_idle;
    logic [1:0] fsm_state;

    uart_tx_periph_if bus ();

    uart_tx_periph #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .MAINCLK   (MAINCLK),
        .MAINRST   (MAINRST),
        .bus       (bus.slave),
        .tx        (tx),
        .tx_idle   (tx_idle),
        .fsm_state (fsm_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic       tx_hist [HIST];
    logic [7:0] exp_q [$];
    logic [7:0] burst_q [$];

    // clock / reset
    initial MAINCLK = 1'b0;
    always #5 MAINCLK = ~MAINCLK;
    always @(posedge MAINCLK) cyc <= cyc + 1;
    // tx_hist[k] holds the tx value registered at rising edge k
    always @(negedge MAINCLK) tx_hist[cyc % HIST] = tx;

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic bus_idle();
        bus.bus_sel   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        bus.bus_addr  = 1'b0;
        bus.bus_wdata = 8'h00;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, output int wr_edge);
        bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_re = 1'b0;
        bus.bus_addr = a; bus.bus_wdata = d;
        @(negedge MAINCLK);
        wr_edge = cyc;
        bus_idle();
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        bus.bus_sel = 1'b1; bus.bus_re = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = a;
        @(negedge MAINCLK);
        d = bus.bus_rdata;
        bus_idle();
    endtask

    task automatic bus_burst(output int first_edge);
        first_edge = 0;
        for (int i = 0; i < burst_q.size(); i++) begin
            bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_re = 1'b0;
            bus.bus_addr = 1'b0; bus.bus_wdata = burst_q[i];
            @(negedge MAINCLK);
            if (i == 0) first_edge = cyc;
        end
        bus_idle();
    endtask

    function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
        logic [9:0] f;
        logic [FRAME-1:0] w;
        f = {1'b1, b, 1'b0};
        for (int j = 0; j < FRAME; j++) w[j] = f[j / CLK_DIV];
        return w;
    endfunction

    // scoreboard: every queued byte must appear as a contiguous frame from wr_edge+2
    task automatic check_stream(input string name, input int wr_edge);
        int n, first, last, guard;
        logic [7:0] b;
        logic [FRAME-1:0] obs, expv;
        n = exp_q.size();
        first = wr_edge + 2;
        last = first + n * FRAME;
        guard = 0;
        while (cyc < last + 2 && guard < 20000) begin
            @(negedge MAINCLK);
            guard++;
        end
        checks++;
        if (cyc < last + 2) begin
            failures++;
            $display("FAIL %s timeout cyc=%0d need=%0d", name, cyc, last + 2);
        end
        checks++;
        if (tx_hist[(first - 1) % HIST] !== 1'b1) begin
            failures++;
            $display("FAIL %s pre_start tx=%b exp=1", name, tx_hist[(first - 1) % HIST]);
        end
        for (int k = 0; k < n; k++) begin
            b = exp_q.pop_front();
            expv = frame_wave(b);
            for (int j = 0; j < FRAME; j++) obs[j] = tx_hist[(first + k * FRAME + j) % HIST];
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL %s frame%0d byte=%h got=%h exp=%h", name, k, b, obs, expv);
            end
        end
        checks++;
        if (tx_hist[last % HIST] !== 1'b1) begin
            failures++;
            $display("FAIL %s post_idle tx=%b exp=1", name, tx_hist[last % HIST]);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        MAINRST = 1'b1;
        bus_idle();
        @(negedge MAINCLK);
        @(negedge MAINCLK);
        checks++;
        if ({tx, tx_idle, fsm_state, bus.bus_rdata} !== {1'b1, 1'b1, 2'd0, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs got tx=%b idle=%b st=%0d rdata=%h exp 1 1 0 00",
                     tx, tx_idle, fsm_state, bus.bus_rdata);
        end
        MAINRST = 1'b0;
        @(negedge MAINCLK);
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL reset_status got=%h exp=02", d); end
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL read_data got=%h exp=00", d); end
    endtask

    task automatic test_single_byte();
        int n;
        bus_write(1'b0, 8'h55, n);
        checks++;
        if (tx_idle !== 1'b0) begin failures++; $display("FAIL single_idle_fall got=%b exp=0", tx_idle); end
        while (cyc < n + 40) @(negedge MAINCLK);
        checks++;
        if (tx_idle !== 1'b0) begin failures++; $display("FAIL single_idle_stop got=%b exp=0", tx_idle); end
        @(negedge MAINCLK);
        checks++;
        if (tx_idle !== 1'b1 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL single_idle_rise idle=%b st=%0d exp 1 0", tx_idle, fsm_state);
        end
        exp_q.push_back(8'h55);
        check_stream("single", n);
    endtask

    task automatic test_back_to_back();
        int n;
        burst_q = '{8'hA5, 8'h3C};
        bus_burst(n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        check_stream("b2b", n);
    endtask

    task automatic test_overflow();
        int n, w;
        logic [7:0] d;
        burst_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        bus_burst(n);
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h0D) begin failures++; $display("FAIL ovf_status got=%h exp=0D", d); end
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        check_stream("ovf", n);
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h0A) begin failures++; $display("FAIL ovf_sticky got=%h exp=0A", d); end
        bus_write(1'b1, 8'h01, w);
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL ovf_clear got=%h exp=02", d); end
    endtask

    task automatic test_collision();
        int n;
        logic [7:0] d;
        burst_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        bus_burst(n);
        bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_re = 1'b1;
        bus.bus_addr = 1'b1; bus.bus_wdata = 8'h01;
        @(negedge MAINCLK);
        d = bus.bus_rdata;
        bus_idle();
        checks++;
        if (d !== 8'h0D) begin failures++; $display("FAIL collide_pre got=%h exp=0D", d); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h05) begin failures++; $display("FAIL collide_post got=%h exp=05", d); end
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
        check_stream("collide", n);
    endtask

    task automatic test_reset_mid_frame();
        int n, bad;
        logic [7:0] d;
        burst_q = '{8'hA5, 8'hC3};
        bus_burst(n);
        while (cyc < n + 19) @(negedge MAINCLK);
        checks++;
        if (tx !== 1'b0 || fsm_state !== 2'd2) begin
            failures++;
            $display("FAIL midrst_bit3 tx=%b st=%0d exp 0 2", tx, fsm_state);
        end
        MAINRST = 1'b1;
        #1;
        checks++;
        if ({tx, tx_idle, fsm_state, bus.bus_rdata} !== {1'b1, 1'b1, 2'd0, 8'h00}) begin
            failures++;
            $display("FAIL midrst_async tx=%b idle=%b st=%0d rdata=%h exp 1 1 0 00",
                     tx, tx_idle, fsm_state, bus.bus_rdata);
        end
        @(negedge MAINCLK);
        @(negedge MAINCLK);
        MAINRST = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge MAINCLK);
            if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midrst_quiet active_cycles=%0d exp=0", bad); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL midrst_status got=%h exp=02", d); end
    endtask

    initial begin
        MAINRST = 1'b1;
        bus_idle();
        @(negedge MAINCLK);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_collision();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
